cfi_elp_tracker: RTL and testbench

//  Zicfilp expected-landing-pad (ELP) state tracker at commit, downstream of the branch unit.
//  - Arms ELP on commit of an indirect JALR.
//  - Feeds elp_o back to the branch unit.
//  - Consumes the branch unit's complete_cfi code for the following instruction.
//  - Raises a software-check fault on a missing or mismatched LPAD.
//  - Saves/restores ELP across traps and xRET.

---
 rtl/cfi_elp_tracker.sv | 136 +++++++++++++
 tb/tb_cfi_elp_tracker.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cfi_elp_tracker.sv
// Zicfilp expected-landing-pad tracker at commit: arms on indirect JALR, checks the next head for LPAD.
// Optional CVA6_LP_STATS_EN adds saturating match/fault counters.
module cfi_elp_tracker #(
   parameter int unsigned NrCommitPorts = 1,
   parameter int unsigned XLEN          = 64,
   parameter int unsigned STAT_W        = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     xlpad_en_i,
   input  logic [NrCommitPorts-1:0] commit_valid_i,
   input  logic                     commit_jalr_i,
   input  logic [4:0]               commit_rs1_i,
   input  logic                     head_valid_i,
   input  logic                     head_is_lpad_i,
   input  logic [1:0]               complete_cfi_i,
   input  logic                     trap_i,
   input  logic                     xret_i,
   input  logic                     pelp_i,
   output logic                     elp_o,
   output logic                     pelp_o,
   output logic                     sw_check_o,
   output logic [XLEN-1:0]          sw_check_tval_o,
`ifdef CVA6_LP_STATS_EN
   output logic [STAT_W-1:0]        lp_match_cnt_o,
   output logic [STAT_W-1:0]        lp_fault_cnt_o,
`endif
   output logic                     block_port1_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_EXPECT = 2'b01,
      S_FAULT  = 2'b10
   } state_t;

   state_t r_state;
   logic   r_elp;

   logic w_arm;
   logic w_lp_match;
   logic w_unused;

   // x1/x5/x7 are link registers: returns and software-guarded jumps need no landing pad
   assign w_arm = commit_valid_i[0] & commit_jalr_i & xlpad_en_i &
                  (commit_rs1_i != 5'd1) & (commit_rs1_i != 5'd5) & (commit_rs1_i != 5'd7);
   assign w_lp_match = head_is_lpad_i & (complete_cfi_i == 2'b11);
   assign w_unused   = ^commit_valid_i;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
         r_elp   <= 1'b0;
      end else if (trap_i) begin
         r_state <= S_IDLE;
         r_elp   <= 1'b0;
      end else if (xret_i) begin
         if (pelp_i && xlpad_en_i) begin
            r_state <= S_EXPECT;
            r_elp   <= 1'b1;
         end else begin
            r_state <= S_IDLE;
            r_elp   <= 1'b0;
         end
      end else if (!xlpad_en_i) begin
         r_state <= S_IDLE;
         r_elp   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_arm) begin
                  r_state <= S_EXPECT;
                  r_elp   <= 1'b1;
               end
            end
            S_EXPECT: begin
               if (head_valid_i) begin
                  if (w_lp_match) begin
                     r_state <= S_IDLE;
                     r_elp   <= 1'b0;
                  end else begin
                     r_state <= S_FAULT;
                     r_elp   <= 1'b1;
                  end
               end
            end
            S_FAULT: begin
               r_state <= S_FAULT;
               r_elp   <= 1'b1;
            end
            default: begin
               r_state <= S_IDLE;
               r_elp   <= 1'b0;
            end
         endcase
      end
   end

   assign elp_o           = r_elp;
   assign pelp_o          = trap_i & (r_state != S_IDLE);
   assign sw_check_o      = xlpad_en_i & ((r_state == S_FAULT) |
                            ((r_state == S_EXPECT) & head_valid_i & ~w_lp_match));
   assign sw_check_tval_o = XLEN'(2);
   // Port 1 is held off so the instruction after an arming JALR always reaches port 0
   assign block_port1_o   = (NrCommitPorts > 1) & ((r_state != S_IDLE) | w_arm);

`ifdef CVA6_LP_STATS_EN
   logic              w_ctl_free;
   logic              w_match_evt;
   logic              w_fault_evt;
   logic [STAT_W-1:0] r_match_cnt;
   logic [STAT_W-1:0] r_fault_cnt;

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (&v) ? v : v + STAT_W'(1);
   endfunction

   assign w_ctl_free  = ~trap_i & ~xret_i & xlpad_en_i;
   assign w_match_evt = w_ctl_free & (r_state == S_EXPECT) & head_valid_i & w_lp_match;
   assign w_fault_evt = w_ctl_free & (r_state == S_EXPECT) & head_valid_i & ~w_lp_match;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_match_cnt <= '0;
         r_fault_cnt <= '0;
      end else begin
         if (w_match_evt) r_match_cnt <= sat_inc(r_match_cnt);
         if (w_fault_evt) r_fault_cnt <= sat_inc(r_fault_cnt);
      end
   end

   assign lp_match_cnt_o = r_match_cnt;
   assign lp_fault_cnt_o = r_fault_cnt;
`endif

endmodule

// File: tb/tb_cfi_elp_tracker.sv
// Directed bench for cfi_elp_tracker (two commit ports); counter checks enabled with CVA6_LP_STATS_EN.
module tb_cfi_elp_tracker;

   localparam int unsigned NCP    = 2;
   localparam int unsigned XLEN   = 64;
   localparam int unsigned STAT_W = 16;

   logic             clk_i = 1'b0;
   logic             rst_ni;
   logic             xlpad_en_i;
   logic [NCP-1:0]   commit_valid_i;
   logic             commit_jalr_i;
   logic [4:0]       commit_rs1_i;
   logic             head_valid_i;
   logic             head_is_lpad_i;
   logic [1:0]       complete_cfi_i;
   logic             trap_i;
   logic             xret_i;
   logic             pelp_i;
   logic             elp_o;
   logic             pelp_o;
   logic             sw_check_o;
   logic [XLEN-1:0]  sw_check_tval_o;
   logic             block_port1_o;
`ifdef CVA6_LP_STATS_EN
   logic [STAT_W-1:0] lp_match_cnt_o;
   logic [STAT_W-1:0] lp_fault_cnt_o;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk_i = ~clk_i;

   cfi_elp_tracker #(.NrCommitPorts(NCP), .XLEN(XLEN), .STAT_W(STAT_W)) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .xlpad_en_i      (xlpad_en_i),
      .commit_valid_i  (commit_valid_i),
      .commit_jalr_i   (commit_jalr_i),
      .commit_rs1_i    (commit_rs1_i),
      .head_valid_i    (head_valid_i),
      .head_is_lpad_i  (head_is_lpad_i),
      .complete_cfi_i  (complete_cfi_i),
      .trap_i          (trap_i),
      .xret_i          (xret_i),
      .pelp_i          (pelp_i),
      .elp_o           (elp_o),
      .pelp_o          (pelp_o),
      .sw_check_o      (sw_check_o),
      .sw_check_tval_o (sw_check_tval_o),
`ifdef CVA6_LP_STATS_EN
      .lp_match_cnt_o  (lp_match_cnt_o),
      .lp_fault_cnt_o  (lp_fault_cnt_o),
`endif
      .block_port1_o   (block_port1_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic quiet();
      commit_valid_i = '0;
      commit_jalr_i  = 1'b0;
      commit_rs1_i   = 5'd0;
      head_valid_i   = 1'b0;
      head_is_lpad_i = 1'b0;
      complete_cfi_i = 2'b01;
      trap_i         = 1'b0;
      xret_i         = 1'b0;
      pelp_i         = 1'b0;
   endtask

   // drive a committing JALR for one cycle
   task automatic jalr(input logic [4:0] rs1);
      commit_valid_i = 2'b01;
      commit_jalr_i  = 1'b1;
      commit_rs1_i   = rs1;
      tick();
      quiet();
   endtask

   // present a head instruction for one cycle, checking sw_check_o combinationally
   task automatic head(input logic lpad, input logic [1:0] cfi, input logic exp_sw, input string tag);
      head_valid_i   = 1'b1;
      head_is_lpad_i = lpad;
      complete_cfi_i = cfi;
      #1;
      chk(tag, 64'(sw_check_o), 64'(exp_sw));
      tick();
      quiet();
   endtask

   task automatic trap_cycle();
      trap_i = 1'b1;
      #1;
      chk("pelp_on_trap", 64'(pelp_o), 64'd1);
      tick();
      quiet();
   endtask

   initial begin
      quiet();
      xlpad_en_i = 1'b1;
      rst_ni     = 1'b0;
      tick();
      tick();
      chk("rst_elp",   64'(elp_o), 64'd0);
      chk("rst_sw",    64'(sw_check_o), 64'd0);
      chk("rst_pelp",  64'(pelp_o), 64'd0);
      chk("rst_block", 64'(block_port1_o), 64'd0);
      chk("rst_tval",  sw_check_tval_o, 64'd2);
      rst_ni = 1'b1;
      tick();
      chk("idle_elp", 64'(elp_o), 64'd0);

      // JALR x6 then matching LPAD
      commit_valid_i = 2'b01; commit_jalr_i = 1'b1; commit_rs1_i = 5'd6;
      #1;
      chk("arm_block", 64'(block_port1_o), 64'd1);
      tick();
      quiet();
      chk("t2_elp_hi", 64'(elp_o), 64'd1);
      chk("t2_block",  64'(block_port1_o), 64'd1);
      head(1'b1, 2'b11, 1'b0, "t2_sw_match");
      chk("t2_elp_lo", 64'(elp_o), 64'd0);
      chk("t2_block_lo", 64'(block_port1_o), 64'd0);

      // JALR x6 then non-LPAD head -> fault held until trap
      jalr(5'd6);
      chk("t3_elp", 64'(elp_o), 64'd1);
      head(1'b0, 2'b01, 1'b1, "t3_sw_now");
      chk("t3_tval", sw_check_tval_o, 64'd2);
      chk("t3_sw_hold1", 64'(sw_check_o), 64'd1);
      chk("t3_elp_fault", 64'(elp_o), 64'd1);
      tick();
      chk("t3_sw_hold2", 64'(sw_check_o), 64'd1);
      trap_cycle();
      chk("t3_elp_after", 64'(elp_o), 64'd0);
      chk("t3_sw_after", 64'(sw_check_o), 64'd0);
      chk("t3_pelp_after", 64'(pelp_o), 64'd0);

      // link-register JALRs do not arm
      commit_valid_i = 2'b01; commit_jalr_i = 1'b1; commit_rs1_i = 5'd1;
      #1;
      chk("t4_block_x1", 64'(block_port1_o), 64'd0);
      tick();
      quiet();
      chk("t4_elp_x1", 64'(elp_o), 64'd0);
      jalr(5'd7);
      chk("t4_elp_x7", 64'(elp_o), 64'd0);
      jalr(5'd5);
      chk("t4_elp_x5", 64'(elp_o), 64'd0);
      head(1'b0, 2'b01, 1'b0, "t4_sw_pass");

      // trap beats simultaneous arming
      commit_valid_i = 2'b01; commit_jalr_i = 1'b1; commit_rs1_i = 5'd6; trap_i = 1'b1;
      #1;
      chk("prio_pelp_idle", 64'(pelp_o), 64'd0);
      tick();
      quiet();
      chk("prio_trap_arm", 64'(elp_o), 64'd0);

      // trap in EXPECT, xRET restores, LPAD with code 00 faults
      jalr(5'd6);
      chk("t5_elp", 64'(elp_o), 64'd1);
      trap_cycle();
      chk("t5_elp_trap", 64'(elp_o), 64'd0);
      xret_i = 1'b1; pelp_i = 1'b1;
      tick();
      quiet();
      chk("t5_elp_xret", 64'(elp_o), 64'd1);
      head(1'b1, 2'b00, 1'b1, "t5_sw_code00");
      chk("t5_sw_hold", 64'(sw_check_o), 64'd1);
      trap_cycle();
      chk("t5_elp_end", 64'(elp_o), 64'd0);

      // xRET with pelp_i=0 leaves IDLE
      xret_i = 1'b1; pelp_i = 1'b0;
      tick();
      quiet();
      chk("xret_pelp0", 64'(elp_o), 64'd0);

      // disable landing pads during EXPECT
      jalr(5'd6);
      chk("t6_elp", 64'(elp_o), 64'd1);
      xlpad_en_i = 1'b0;
      head(1'b0, 2'b01, 1'b0, "t6_sw_dis");
      xlpad_en_i = 1'b1;
      chk("t6_elp_off", 64'(elp_o), 64'd0);
      chk("t6_sw_off", 64'(sw_check_o), 64'd0);

`ifdef CVA6_LP_STATS_EN
      rst_ni = 1'b0;
      tick();
      tick();
      rst_ni = 1'b1;
      chk("cnt_rst_m", 64'(lp_match_cnt_o), 64'd0);
      chk("cnt_rst_f", 64'(lp_fault_cnt_o), 64'd0);
      for (int i = 0; i < 3; i++) begin
         jalr(5'd10);
         head(1'b1, 2'b11, 1'b0, "cnt_match_sw");
      end
      jalr(5'd10);
      head(1'b0, 2'b10, 1'b1, "cnt_fault_sw");
      tick();
      trap_cycle();
      chk("cnt_match", 64'(lp_match_cnt_o), 64'd3);
      chk("cnt_fault", 64'(lp_fault_cnt_o), 64'd1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
